// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - frames a flat word stream into AXI-Stream packets
// Main output register plus one skid entry sustains full rate under backpressure.
module axis_packetizer #(
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  input  logic [DATA_WIDTH_BYTES-1:0]   cfg_last_keep,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH_BYTES*8-1:0] in_data,
  input  logic                          in_last,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_WIDTH_BYTES*8-1:0] m_tdata,
  output logic [DATA_WIDTH_BYTES-1:0]   m_tkeep,
  output logic                          m_tlast,
  output logic                          busy,
  output logic [LEN_WIDTH-1:0]          pkt_count,
  output logic                          err_zero_len
);

  localparam int DW = DATA_WIDTH_BYTES * 8;
  localparam int KW = DATA_WIDTH_BYTES;

  logic [LEN_WIDTH-1:0] r_beat_cnt;
  logic [LEN_WIDTH-1:0] r_len_q;
  logic [KW-1:0]        r_keep_q;
  logic                 r_in_ready;
  logic                 r_m_tvalid;
  logic [DW-1:0]        r_m_tdata;
  logic [KW-1:0]        r_m_tkeep;
  logic                 r_m_tlast;
  logic                 r_s_valid;
  logic [DW-1:0]        r_s_data;
  logic [KW-1:0]        r_s_keep;
  logic                 r_s_last;
  logic [LEN_WIDTH-1:0] r_pkt_count;
  logic                 r_err_zero_len;

  logic                 w_first;
  logic                 w_zero_len;
  logic [LEN_WIDTH-1:0] w_len;
  logic [KW-1:0]        w_keep_cfg;
  logic [KW-1:0]        w_keep;
  logic                 w_last;
  logic [KW-1:0]        w_beat_keep;
  logic                 w_acc;
  logic                 w_hs;
  logic                 w_skid_nxt;

  // First beat of a packet uses the configuration sampled in that same cycle.
  always_comb begin
    w_first     = (r_beat_cnt == '0);
    w_zero_len  = (cfg_len == '0);
    w_len       = w_first ? (w_zero_len ? LEN_WIDTH'(1) : cfg_len) : r_len_q;
    w_keep_cfg  = (cfg_last_keep == '0) ? '1 : cfg_last_keep;
    w_keep      = w_first ? w_keep_cfg : r_keep_q;
    w_last      = (r_beat_cnt == (w_len - LEN_WIDTH'(1))) || in_last;
    w_beat_keep = w_last ? w_keep : '1;
    w_acc       = in_valid && r_in_ready;
    w_hs        = r_m_tvalid && m_tready;
    if (r_s_valid) begin
      w_skid_nxt = !w_hs;
    end else begin
      w_skid_nxt = w_acc && r_m_tvalid && !m_tready;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_beat_cnt     <= '0;
      r_len_q        <= '0;
      r_keep_q       <= '0;
      r_in_ready     <= 1'b0;
      r_m_tvalid     <= 1'b0;
      r_m_tdata      <= '0;
      r_m_tkeep      <= '0;
      r_m_tlast      <= 1'b0;
      r_s_valid      <= 1'b0;
      r_s_data       <= '0;
      r_s_keep       <= '0;
      r_s_last       <= 1'b0;
      r_pkt_count    <= '0;
      r_err_zero_len <= 1'b0;
    end else begin
      r_in_ready     <= !w_skid_nxt;
      r_err_zero_len <= w_acc && w_first && w_zero_len;

      if (w_acc) begin
        if (w_first) begin
          r_len_q  <= w_len;
          r_keep_q <= w_keep_cfg;
        end
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + LEN_WIDTH'(1);
      end

      if (w_hs && r_m_tlast) begin
        r_pkt_count <= r_pkt_count + LEN_WIDTH'(1);
      end

      // in_ready is low whenever the skid holds a beat, so no accept collides with a skid drain.
      if (r_s_valid) begin
        if (w_hs) begin
          r_m_tdata <= r_s_data;
          r_m_tkeep <= r_s_keep;
          r_m_tlast <= r_s_last;
          r_s_valid <= 1'b0;
        end
      end else if (w_acc) begin
        if (!r_m_tvalid || m_tready) begin
          r_m_tvalid <= 1'b1;
          r_m_tdata  <= in_data;
          r_m_tkeep  <= w_beat_keep;
          r_m_tlast  <= w_last;
        end else begin
          r_s_valid <= 1'b1;
          r_s_data  <= in_data;
          r_s_keep  <= w_beat_keep;
          r_s_last  <= w_last;
        end
      end else if (w_hs) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign m_tvalid     = r_m_tvalid;
  assign m_tdata      = r_m_tdata;
  assign m_tkeep      = r_m_tkeep;
  assign m_tlast      = r_m_tlast;
  assign busy         = (r_beat_cnt != '0) || r_m_tvalid || r_s_valid;
  assign pkt_count    = r_pkt_count;
  assign err_zero_len = r_err_zero_len;

endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - directed bench for axis_packetizer with a packet-level reference model
module tb_axis_packetizer;

  localparam int DWB = 4;
  localparam int LW  = 4;

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic [LW-1:0]   cfg_len = '0;
  logic [DWB-1:0]  cfg_last_keep = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_data = '0;
  logic            in_last = 1'b0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [31:0]     m_tdata;
  logic [DWB-1:0]  m_tkeep;
  logic            m_tlast;
  logic            busy;
  logic [LW-1:0]   pkt_count;
  logic            err_zero_len;

  axis_packetizer #(.DATA_WIDTH_BYTES(DWB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .arstn(arstn), .cfg_len(cfg_len), .cfg_last_keep(cfg_last_keep),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .busy(busy), .pkt_count(pkt_count), .err_zero_len(err_zero_len)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expected beats queued on acceptance, retired on handshake.
  logic [31:0]    exp_data[$];
  logic [DWB-1:0] exp_keep[$];
  logic           exp_last[$];
  int             m_pos = 0;
  int             m_len = 1;
  logic [DWB-1:0] m_keep = '1;
  int             m_pkts = 0;
  logic           m_err_pend = 1'b0;
  int             err_seen = 0;
  int             ready_low = 0;

  logic [31:0]    log_data[$];
  logic [DWB-1:0] log_keep[$];
  logic           log_last[$];

  logic           prev_stall = 1'b0;
  logic [31:0]    prev_data;
  logic [DWB-1:0] prev_keep;
  logic           prev_last;

  always @(negedge clk) begin
    if (!arstn) begin
      exp_data.delete(); exp_keep.delete(); exp_last.delete();
      m_pos = 0; m_pkts = 0; m_err_pend = 1'b0; prev_stall = 1'b0;
    end else begin
      check("pkt_count", {28'd0, pkt_count}, m_pkts % 16);
      check("busy", {31'd0, busy}, {31'd0, (exp_data.size() != 0) || (m_pos != 0)});
      check("err_zero_len", {31'd0, err_zero_len}, {31'd0, m_err_pend});
      if (err_zero_len) err_seen++;
      if (!in_ready) ready_low++;
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_tvalid}, 32'd1);
        check("hold_data", m_tdata, prev_data);
        check("hold_keep_last", {27'd0, m_tkeep, m_tlast}, {27'd0, prev_keep, prev_last});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata; prev_keep = m_tkeep; prev_last = m_tlast;

      if (m_tvalid && m_tready) begin
        log_data.push_back(m_tdata); log_keep.push_back(m_tkeep); log_last.push_back(m_tlast);
        if (exp_data.size() == 0) begin
          check("unexpected_beat", m_tdata, 32'hFFFF_FFFF);
        end else begin
          check("beat_data", m_tdata, exp_data.pop_front());
          check("beat_keep", {28'd0, m_tkeep}, {28'd0, exp_keep.pop_front()});
          check("beat_last", {31'd0, m_tlast}, {31'd0, exp_last.pop_front()});
          if (m_tlast) m_pkts++;
        end
      end

      m_err_pend = 1'b0;
      if (in_valid && in_ready) begin
        logic lst;
        if (m_pos == 0) begin
          m_len  = (cfg_len == 0) ? 1 : int'(cfg_len);
          m_keep = (cfg_last_keep == 0) ? 4'hF : cfg_last_keep;
          m_err_pend = (cfg_len == 0);
        end
        lst = (m_pos == m_len - 1) || in_last;
        exp_data.push_back(in_data);
        exp_keep.push_back(lst ? m_keep : 4'hF);
        exp_last.push_back(lst);
        m_pos = lst ? 0 : m_pos + 1;
      end
    end
  end

  logic tr_mode  = 1'b0;
  logic tr_fixed = 1'b0;
  int   tr_phase = 0;
  initial forever begin
    @(posedge clk); #1;
    m_tready = tr_mode ? (tr_phase % 3 == 0) : tr_fixed;
    tr_phase++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arstn = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    arstn = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_log();
    log_data.delete(); log_keep.delete(); log_last.delete();
  endtask

  initial begin
    // Reset state
    arstn = 1'b0;
    tick(); tick();
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_outputs", {m_tdata[23:0], m_tkeep, m_tlast, busy, err_zero_len, 1'b0}, 32'd0);
    check("rst_pkt_count", {28'd0, pkt_count}, 32'd0);
    arstn = 1'b1;
    tick();
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Test 1: 3-beat packet, no backpressure
    cfg_len = 4'd3; cfg_last_keep = 4'b0011; tr_fixed = 1'b1;
    tick(); clear_log();
    push(32'h08, 1'b0);
    check("t1_latency", {m_tvalid, m_tdata[30:0]}, 32'h8000_0008);
    push(32'h20, 1'b0);
    push(32'h28, 1'b0);
    idle(); wait_drain();
    check("t1_count", log_data.size(), 3);
    if (log_data.size() == 3) begin
      check("t1_d0", log_data[0], 32'h08); check("t1_d1", log_data[1], 32'h20);
      check("t1_d2", log_data[2], 32'h28);
      check("t1_keep", {20'd0, log_keep[0], log_keep[1], log_keep[2]}, 32'hFF3);
      check("t1_last", {29'd0, log_last[0], log_last[1], log_last[2]}, 32'd1);
    end
    check("t1_pkt_count", {28'd0, pkt_count}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Test 2: 4-beat packets, ready pattern 1,0,0
    do_reset();
    cfg_len = 4'd4; cfg_last_keep = 4'hF; clear_log(); ready_low = 0;
    tr_mode = 1'b1;
    for (int i = 0; i < 8; i++) push(32'h100 + i, 1'b0);
    idle(); wait_drain();
    tr_mode = 1'b0;
    check("t2_count", log_data.size(), 8);
    for (int i = 0; i < 8 && i < log_data.size(); i++) begin
      check("t2_order", log_data[i], 32'h100 + i);
      check("t2_last", {31'd0, log_last[i]}, {31'd0, (i == 3 || i == 7)});
    end
    check("t2_pkt_count", {28'd0, pkt_count}, 32'd2);
    check("t2_skid_filled", {31'd0, ready_low > 0}, 32'd1);

    // Test 3: early end via in_last
    do_reset();
    cfg_len = 4'd5; cfg_last_keep = 4'b0111; tr_fixed = 1'b1; clear_log();
    push(32'hA, 1'b0);
    push(32'hB, 1'b1);
    push(32'hC, 1'b0);
    idle(); tick(); tick(); tick();
    check("t3_count", log_data.size(), 3);
    if (log_data.size() == 3) begin
      check("t3_last", {29'd0, log_last[0], log_last[1], log_last[2]}, 32'b010);
      check("t3_keepB", {28'd0, log_keep[1]}, 32'h7);
      check("t3_dataC", log_data[2], 32'hC);
    end
    check("t3_pkt_count", {28'd0, pkt_count}, 32'd1);
    check("t3_busy_open", {31'd0, busy}, 32'd1);

    // Test 4: zero length becomes one-beat packets
    do_reset();
    cfg_len = 4'd0; cfg_last_keep = 4'd0; clear_log(); err_seen = 0;
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    idle(); wait_drain(); tick();
    check("t4_count", log_data.size(), 2);
    if (log_data.size() == 2) begin
      check("t4_last", {30'd0, log_last[0], log_last[1]}, 32'b11);
      check("t4_keep", {24'd0, log_keep[0], log_keep[1]}, 32'hFF);
    end
    check("t4_err_pulses", err_seen, 2);
    check("t4_pkt_count", {28'd0, pkt_count}, 32'd2);

    // Test 5: reset mid-packet
    do_reset();
    cfg_len = 4'd4; cfg_last_keep = 4'hF; tr_fixed = 1'b0; tick();
    push(32'h41, 1'b0);
    push(32'h42, 1'b0);
    idle();
    check("t5_skid_full", {31'd0, in_ready}, 32'd0);
    arstn = 1'b0; clear_log();
    tick();
    check("t5_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    arstn = 1'b1; tr_fixed = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push(32'h51 + i, 1'b0);
    idle(); wait_drain();
    check("t5_count", log_data.size(), 4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      check("t5_data", log_data[i], 32'h51 + i);
      check("t5_last", {31'd0, log_last[i]}, {31'd0, i == 3});
    end
    check("t5_pkt_count", {28'd0, pkt_count}, 32'd1);

    // Test 6: pkt_count wrap at LEN_WIDTH=4
    do_reset();
    cfg_len = 4'd1; cfg_last_keep = 4'hF;
    for (int i = 1; i <= 17; i++) begin
      push(32'h200 + i, 1'b0);
      idle(); wait_drain();
      if (i == 15) check("t6_pc15", {28'd0, pkt_count}, 32'd15);
      if (i == 16) check("t6_pc16", {28'd0, pkt_count}, 32'd0);
      if (i == 17) check("t6_pc17", {28'd0, pkt_count}, 32'd1);
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
